// File: rtl/fifo_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_serial_pkg
// Brief    : Shared types and constants for the FIFO-to-serial drain.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        CAP   = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

    localparam logic TX_IDLE    = 1'b1;
    localparam logic TX_START   = 1'b0;
    localparam int   BYTE_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_serial_drain_bit_tick.sv
`default_nettype none
// ============================================================================
// Module   : fifo_serial_drain_bit_tick
// Brief    : Bit-period counter; tick_o marks the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_serial_drain_bit_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_w,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_w or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_serial_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_serial_drain
// Brief    : Pops bytes from the FIFO read port and shifts them out as
//            asynchronous serial frames (start, data LSB first, stop).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_serial_drain
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk_w,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_W-1:0]     fifo_rdd_i,
    output logic                  fifo_rde_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  byte_done_o,
    output logic [BYTE_CNT_W-1:0] byte_cnt_o
);

    // Index is shared between data bits and stop bits, so size it for both.
    localparam int IDX_W = $clog2(DATA_W + 1);

    state_e                  state_q, state_d;
    logic                    rde_q, rde_d;
    logic                    tx_q, tx_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;

    logic                    w_tick;
    logic                    w_clear;
    logic                    w_last_data;
    logic                    w_last_stop;
    logic [DATA_W-1:0]       w_shift_nxt;

    assign w_clear     = (state_q == IDLE) || (state_q == REQ) || (state_q == CAP);
    assign w_last_data = (idx_q == IDX_W'(DATA_W - 1));
    assign w_last_stop = (state_q == STOP) && w_tick && (idx_q == IDX_W'(STOP_BITS - 1));
    assign w_shift_nxt = shift_q >> 1;

    fifo_serial_drain_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick (
        .clk_w   (clk_w),
        .reset   (reset),
        .clear_i (w_clear),
        .tick_o  (w_tick)
    );

    always_ff @(posedge clk_w or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rde_q   <= 1'b0;
            tx_q    <= TX_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rde_q   <= rde_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i && !fifo_empty_i) state_d = REQ;
            REQ:     state_d = CAP;
            CAP:     state_d = START;
            START:   if (w_tick) state_d = DATA;
            DATA:    if (w_tick && w_last_data) state_d = STOP;
            STOP:    if (w_last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rde_d   = 1'b0;
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE;
                if (enable_i && !fifo_empty_i) rde_d = 1'b1;
            end
            REQ: tx_d = TX_IDLE;
            CAP: begin
                // Read data is valid this cycle, one edge after the strobe.
                shift_d = fifo_rdd_i;
                tx_d    = TX_START;
                idx_d   = '0;
            end
            START: begin
                if (w_tick) begin
                    tx_d  = shift_q[0];
                    idx_d = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    shift_d = w_shift_nxt;
                    if (w_last_data) begin
                        tx_d  = TX_IDLE;
                        idx_d = '0;
                    end else begin
                        tx_d  = w_shift_nxt[0];
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = TX_IDLE;
                if (w_last_stop) begin
                    cnt_d = cnt_q + 1'b1;
                    idx_d = '0;
                end else if (w_tick) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                tx_d  = TX_IDLE;
                idx_d = '0;
            end
        endcase
    end

    assign fifo_rde_o  = rde_q;
    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE);
    assign byte_done_o = w_last_stop;
    assign byte_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_serial_drain
// Brief    : Self-checking bench; FIFO models and a frame-stream reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_serial_drain;

    logic clk_w = 1'b0;
    always #5 clk_w = ~clk_w;

    // DUT A: defaults (8 data bits, 4 clocks/bit, 1 stop bit)
    logic        reset = 1'b1, enable = 1'b0, fifo_empty = 1'b1;
    logic [7:0]  fifo_rdd = 8'h00;
    logic        fifo_rde, tx, busy, byte_done;
    logic [15:0] byte_cnt;
    // DUT B: 1 clock/bit, 2 stop bits
    logic        reset_b = 1'b1, enable_b = 1'b0, fifo_empty_b = 1'b1;
    logic [7:0]  fifo_rdd_b = 8'h00;
    logic        fifo_rde_b, tx_b, busy_b, byte_done_b;
    logic [15:0] byte_cnt_b;

    fifo_serial_drain dut_a (
        .clk_w(clk_w), .reset(reset), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_rdd_i(fifo_rdd), .fifo_rde_o(fifo_rde), .tx_o(tx), .busy_o(busy),
        .byte_done_o(byte_done), .byte_cnt_o(byte_cnt));

    fifo_serial_drain #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
        .clk_w(clk_w), .reset(reset_b), .enable_i(enable_b), .fifo_empty_i(fifo_empty_b),
        .fifo_rdd_i(fifo_rdd_b), .fifo_rde_o(fifo_rde_b), .tx_o(tx_b), .busy_o(busy_b),
        .byte_done_o(byte_done_b), .byte_cnt_o(byte_cnt_b));

    int tests_run = 0, tests_failed = 0;
    logic [7:0] fifo_a[$], fifo_b[$], model_bytes[$];
    bit   exp_tx[$], exp_rde[$], exp_done[$];
    logic obs_tx[$], obs_rde[$], obs_done[$];
    logic prev_rde_a = 1'b0, prev_rde_b = 1'b0;

    // FIFO models: registered read data, empty flag follows the queue.
    always @(posedge clk_w or negedge clk_w) begin
        if (clk_w) begin
            if (fifo_rde) begin
                tests_run++;
                if (fifo_a.size() == 0 || prev_rde_a) begin
                    tests_failed++;
                    $display("FAIL rde_protocol_a: fifo_size=%0d prev_rde=%b, required size>0 and prev_rde=0",
                             fifo_a.size(), prev_rde_a);
                end
                if (fifo_a.size() != 0) fifo_rdd <= fifo_a.pop_front();
            end
            if (fifo_rde_b) begin
                tests_run++;
                if (fifo_b.size() == 0 || prev_rde_b) begin
                    tests_failed++;
                    $display("FAIL rde_protocol_b: fifo_size=%0d prev_rde=%b, required size>0 and prev_rde=0",
                             fifo_b.size(), prev_rde_b);
                end
                if (fifo_b.size() != 0) fifo_rdd_b <= fifo_b.pop_front();
            end
            prev_rde_a <= fifo_rde;
            prev_rde_b <= fifo_rde_b;
        end
        fifo_empty   <= (fifo_a.size() == 0);
        fifo_empty_b <= (fifo_b.size() == 0);
    end

    // Reference: per-cycle tx/rde/done starting at the first strobe cycle.
    function automatic void build_expected(input int cpb, input int stops, input int tail);
        logic [7:0] d;
        int nb;
        bit v;
        exp_tx.delete(); exp_rde.delete(); exp_done.delete();
        nb = 1 + 8 + stops;
        for (int j = 0; j < model_bytes.size(); j++) begin
            d = model_bytes[j];
            if (j > 0) begin exp_tx.push_back(1); exp_rde.push_back(0); exp_done.push_back(0); end
            exp_tx.push_back(1); exp_rde.push_back(1); exp_done.push_back(0);
            exp_tx.push_back(1); exp_rde.push_back(0); exp_done.push_back(0);
            for (int k = 0; k < nb; k++) begin
                v = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b1;
                for (int c = 0; c < cpb; c++) begin
                    exp_tx.push_back(v);
                    exp_rde.push_back(0);
                    exp_done.push_back((k == nb - 1) && (c == cpb - 1));
                end
            end
        end
        for (int t = 0; t < tail; t++) begin
            exp_tx.push_back(1); exp_rde.push_back(0); exp_done.push_back(0);
        end
    endfunction

    function automatic int stream_diffs(output int first);
        int nd = 0;
        first = -1;
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (obs_tx[i] !== exp_tx[i] || obs_rde[i] !== exp_rde[i] || obs_done[i] !== exp_done[i]) begin
                if (first < 0) first = i;
                nd++;
            end
        end
        return nd;
    endfunction

    task automatic wait_rde(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((sel ? fifo_rde_b : fifo_rde) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_w);
        end
    endtask

    task automatic capture(input bit sel, input int n, input int drop_at);
        obs_tx.delete(); obs_rde.delete(); obs_done.delete();
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) enable = 1'b0;
            obs_tx.push_back(sel ? tx_b : tx);
            obs_rde.push_back(sel ? fifo_rde_b : fifo_rde);
            obs_done.push_back(sel ? byte_done_b : byte_done);
            @(negedge clk_w);
        end
    endtask

    task automatic reset_a();
        enable = 1'b0;
        @(negedge clk_w);
        reset = 1'b1;
        repeat (2) @(negedge clk_w);
        reset = 1'b0;
        @(negedge clk_w);
    endtask

    task automatic send_and_check(input string name, input int tail, input int drop_at);
        bit ok;
        int nd, fi;
        wait_rde(1'b0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s_timeout: rde not seen within 400 cycles, required a pop", name);
            return;
        end
        build_expected(4, 1, tail);
        capture(1'b0, exp_tx.size(), drop_at);
        nd = stream_diffs(fi);
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL %s_stream: %0d cycles differ, first at %0d: tx/rde/done=%b%b%b required %b%b%b",
                     name, nd, fi, obs_tx[fi], obs_rde[fi], obs_done[fi], exp_tx[fi], exp_rde[fi], exp_done[fi]);
        end
    endtask

    task automatic test_reset();
        fifo_a.push_back(8'h11);
        enable = 1'b1;
        @(negedge clk_w);
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (tx !== 1'b1 || fifo_rde !== 1'b0 || busy !== 1'b0 || byte_cnt !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_state: tx=%b rde=%b busy=%b cnt=%0d, required 1 0 0 0",
                         tx, fifo_rde, busy, byte_cnt);
            end
            @(negedge clk_w);
        end
        enable = 1'b0;
        reset  = 1'b0;
        repeat (5) @(negedge clk_w);
        tests_run++;
        if (fifo_a.size() !== 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_pop: fifo_size=%0d busy=%b, required 1 0", fifo_a.size(), busy);
        end
        enable = 1'b1;
        model_bytes = '{8'h11};
        send_and_check("reset_release", 3, -1);
    endtask

    task automatic test_single_a5();
        int nr = 0, ndn = 0;
        reset_a();
        fifo_a.push_back(8'hA5);
        model_bytes = '{8'hA5};
        enable = 1'b1;
        send_and_check("single_a5", 3, -1);
        foreach (obs_rde[i]) begin nr += int'(obs_rde[i] === 1'b1); ndn += int'(obs_done[i] === 1'b1); end
        tests_run++;
        if (nr != 1 || ndn != 1 || byte_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_a5_counts: rde_pulses=%0d done_pulses=%0d cnt=%0d, required 1 1 1", nr, ndn, byte_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int nr = 0;
        reset_a();
        model_bytes = '{8'h01, 8'h80, 8'hFF};
        foreach (model_bytes[i]) fifo_a.push_back(model_bytes[i]);
        enable = 1'b1;
        send_and_check("back_to_back", 3, -1);
        foreach (obs_rde[i]) nr += int'(obs_rde[i] === 1'b1);
        tests_run++;
        if (nr != 3 || byte_cnt !== 16'd3 || fifo_a.size() != 0) begin
            tests_failed++;
            $display("FAIL back_to_back_counts: rde_pulses=%0d cnt=%0d fifo_size=%0d, required 3 3 0",
                     nr, byte_cnt, fifo_a.size());
        end
    endtask

    task automatic test_enable_drop();
        reset_a();
        fifo_a.push_back(8'h3C);
        fifo_a.push_back(8'h55);
        model_bytes = '{8'h3C};
        enable = 1'b1;
        send_and_check("enable_drop", 20, 10);
        tests_run++;
        if (byte_cnt !== 16'd1 || fifo_a.size() != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_drop_hold: cnt=%0d fifo_size=%0d busy=%b, required 1 1 0",
                     byte_cnt, fifo_a.size(), busy);
        end
        model_bytes = '{8'h55};
        enable = 1'b1;
        send_and_check("enable_resume", 3, -1);
        tests_run++;
        if (byte_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL enable_resume_cnt: cnt=%0d, required 2", byte_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        reset_a();
        fifo_a.push_back(8'h0F);
        fifo_a.push_back(8'hC3);
        enable = 1'b1;
        wait_rde(1'b0, ok);
        // Cycle 23 from the strobe falls inside data bit 4 (a zero for 0x0F).
        repeat (23) @(negedge clk_w);
        tests_run++;
        if (!ok || tx !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_frame_pre: seen=%b tx=%b busy=%b, required 1 0 1", ok, tx, busy);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || byte_cnt !== 16'd0 || byte_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_frame_reset: tx=%b busy=%b cnt=%0d done=%b, required 1 0 0 0",
                     tx, busy, byte_cnt, byte_done);
        end
        @(negedge clk_w);
        reset = 1'b0;
        model_bytes = '{8'hC3};
        send_and_check("after_reset_c3", 3, -1);
        tests_run++;
        if (byte_cnt !== 16'd1 || fifo_a.size() != 0) begin
            tests_failed++;
            $display("FAIL after_reset_counts: cnt=%0d fifo_size=%0d, required 1 0", byte_cnt, fifo_a.size());
        end
    endtask

    task automatic test_random();
        int n;
        reset_a();
        n = 3 + $urandom_range(0, 2);
        model_bytes.delete();
        for (int i = 0; i < n; i++) model_bytes.push_back(8'($urandom));
        foreach (model_bytes[i]) fifo_a.push_back(model_bytes[i]);
        enable = 1'b1;
        send_and_check("random", 3, -1);
        tests_run++;
        if (byte_cnt !== 16'(n)) begin
            tests_failed++;
            $display("FAIL random_cnt: cnt=%0d, required %0d", byte_cnt, n);
        end
    endtask

    task automatic test_cpb1_stop2();
        bit ok;
        int nd, fi;
        @(negedge clk_w);
        reset_b = 1'b0;
        model_bytes = '{8'h00, 8'($urandom)};
        foreach (model_bytes[i]) fifo_b.push_back(model_bytes[i]);
        enable_b = 1'b1;
        wait_rde(1'b1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL cpb1_timeout: rde not seen within 400 cycles, required a pop");
            return;
        end
        build_expected(1, 2, 3);
        capture(1'b1, exp_tx.size(), -1);
        nd = stream_diffs(fi);
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL cpb1_stream: %0d cycles differ, first at %0d: tx/rde/done=%b%b%b required %b%b%b",
                     nd, fi, obs_tx[fi], obs_rde[fi], obs_done[fi], exp_tx[fi], exp_rde[fi], exp_done[fi]);
        end
        tests_run++;
        if (byte_cnt_b !== 16'd2 || busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpb1_cnt: cnt=%0d busy=%b, required 2 0", byte_cnt_b, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        test_cpb1_stop2();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_serial_drain.md
Name: fifo_serial_drain

Overview:
Consumer for the on-chip byte FIFO. Pops bytes over the FIFO read interface (rde strobe, registered rdd, empty flag) and shifts each byte out as an asynchronous serial frame: start bit, DATA_W data bits LSB first, stop bit(s). Sits between the FIFO read side and the chip's serial TX pin, in the same clk_w domain as the FIFO.

Parameters:
DATA_W, 8, data bits per frame; must match FIFO width
CLKS_PER_BIT, 4, clk_w cycles per serial bit; must be >= 1
STOP_BITS, 1, stop bits per frame; must be 1 or 2

Ports:
clk_w  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  allow new pops; sampled only in IDLE
fifo_empty  in  1  FIFO empty flag
fifo_rdd  in  DATA_W  FIFO read data; valid on the cycle after the edge that samples rde=1
fifo_rde  out  1  FIFO read strobe; registered; single-cycle pulse
tx  out  1  serial line; idles high
busy  out  1  high whenever state != IDLE
byte_done  out  1  one-cycle pulse on the last stop-bit cycle
byte_cnt  out  16  frames sent since reset; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (async, immediate): state=IDLE, fifo_rde=0, tx=1, busy=0, byte_done=0, byte_cnt=0. Shift register and counters are cleared.
- Reset during a frame aborts it. tx goes to 1 immediately. A byte already popped is discarded and not re-requested.
- Registered FSM states: IDLE, REQ, CAP, START, DATA, STOP.
- IDLE: if enable=1 and fifo_empty=0, set fifo_rde<=1 and go to REQ. Otherwise stay; tx=1.
- REQ, one cycle: fifo_rde<=0. The FIFO samples rde on this edge and updates rdd. Go to CAP.
- CAP, one cycle: shift_reg<=fifo_rdd; tx<=0; clear the bit-period counter; go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles, then shift right and bit_idx++. After bit DATA_W-1, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. byte_done=1 and byte_cnt++ on the final STOP cycle. Then go to IDLE.
- Frame length, CAP exit to STOP exit: (2+DATA_W) * CLKS_PER_BIT cycles with STOP_BITS=1.
- Inter-frame gap: IDLE, REQ and CAP add exactly 3 tx-high cycles after the stop bit(s).
- fifo_rde must never assert while fifo_empty=1, and is never high for two consecutive cycles.
- fifo_empty and enable are ignored outside IDLE.
- Dropping enable mid-frame: the current frame completes normally, and no further pop occurs.
- Bit-period counter: $clog2(CLKS_PER_BIT)+1 bits, counts 0..CLKS_PER_BIT-1. CLKS_PER_BIT=1 gives one cycle per bit.
- Unreachable state encodings return to IDLE with tx=1.

Decomposition:
- Package fifo_serial_pkg:
  - state enum (IDLE, REQ, CAP, START, DATA, STOP)
  - TX_IDLE=1'b1, TX_START=1'b0
  - BYTE_CNT_W=16
- Sub-module bit_tick: bit-period counter. Inputs clk_w, reset, clear. Output tick, high on the last cycle of each bit. Parameter CLKS_PER_BIT.

Test Plan:
- Reset with FIFO pre-loaded -> tx=1, fifo_rde=0, busy=0, byte_cnt=0 throughout reset. No pop until reset deasserts and enable=1.
- CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1:
  - fifo_rde pulses exactly 1 cycle.
  - tx shows bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40-cycle frame).
  - byte_done pulses once; byte_cnt=1.
- FIFO holds 3 bytes 0x01,0x80,0xFF -> three frames, each separated by exactly 3 extra tx-high cycles. fifo_rde pulses 3 times; byte_cnt=3; FIFO ends empty.
- enable dropped 10 cycles into the frame for 0x3C with 0x55 still queued -> the 0x3C frame completes. No further fifo_rde. 0x55 remains in the FIFO until enable returns.
- reset asserted mid-DATA on 0x0F -> tx=1 immediately, busy=0, byte_cnt=0. After release, the next queued byte 0xC3 is sent intact.
- CLKS_PER_BIT=1, STOP_BITS=2, byte 0x00 -> 11-cycle frame: tx=0 for 9 cycles, then 1 for 2 cycles.
